// File: rtl/ifft_pkg.sv
// Shared definitions for the 8-point radix-2 DIT inverse FFT.
//   state_t   : iteration state, exposed by the top as counter_o
//               (IDLE = 0, S1..S3 = butterfly stage about to be applied).
//   tw_sel_t  : twiddle applied to the lower butterfly operand
//               (TW_1 = 1, TW_J = +j, TW_C1 = c+jc, TW_C3 = -c+jc).
//   TW_C_DEF / TW_SH_DEF : default cos(pi/4) constant and its fraction bits.
//   bitrev3   : 3-bit index reversal used for the DIT input ordering.
package ifft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TW_1  = 2'd0,
    TW_J  = 2'd1,
    TW_C1 = 2'd2,
    TW_C3 = 2'd3
  } tw_sel_t;

  localparam int TW_C_DEF  = 181;
  localparam int TW_SH_DEF = 8;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational complex butterfly with conjugate twiddle and 1/2 scaling.
//   ar/ai, br/bi : upper and lower operands (signed, width bits)
//   tw_sel       : twiddle t applied to b
//   pr/pi        : (a + t*b) >>> 1
//   qr/qi        : (a - t*b) >>> 1
// The sum is formed at width+2 bits and shifted arithmetically, so the
// result truncates toward -inf before being cut back to width bits.
module ifft_bfly
  import ifft_pkg::*;
#(
  parameter int width = 9,
  parameter int tw_c  = TW_C_DEF,
  parameter int tw_sh = TW_SH_DEF
) (
  input  logic signed [width-1:0] ar, ai, br, bi,
  input  tw_sel_t                 tw_sel,
  output logic signed [width-1:0] pr, pi, qr, qi
);

  // Product width: (width+1)-bit operand times a constant below 2^tw_sh,
  // plus headroom so negating the product can never overflow.
  localparam int pw = width + tw_sh + 2;
  localparam logic signed [pw-1:0] c_w = pw'(tw_c);

  logic signed [width:0]   b_dif, b_sum;
  logic signed [pw-1:0]    m_dif, m_sum, m_nsum;
  logic signed [width:0]   tr, ti;
  logic signed [width+1:0] s_r, s_i, d_r, d_i;

  always_comb begin
    b_dif  = (width+1)'(br) - (width+1)'(bi);
    b_sum  = (width+1)'(br) + (width+1)'(bi);
    m_dif  = pw'(b_dif) * c_w;
    m_sum  = pw'(b_sum) * c_w;
    // Negate before the shift so -c terms floor the same way as +c terms.
    m_nsum = -m_sum;

    tr = (width+1)'(br);
    ti = (width+1)'(bi);
    case (tw_sel)
      TW_1: ;
      TW_J: begin
        tr = -(width+1)'(bi);
        ti = (width+1)'(br);
      end
      TW_C1: begin
        tr = (width+1)'(m_dif >>> tw_sh);
        ti = (width+1)'(m_sum >>> tw_sh);
      end
      TW_C3: begin
        tr = (width+1)'(m_nsum >>> tw_sh);
        ti = (width+1)'(m_dif >>> tw_sh);
      end
      default: ;
    endcase

    s_r = (width+2)'(ar) + (width+2)'(tr);
    s_i = (width+2)'(ai) + (width+2)'(ti);
    d_r = (width+2)'(ar) - (width+2)'(tr);
    d_i = (width+2)'(ai) - (width+2)'(ti);

    pr = width'(s_r >>> 1);
    pi = width'(s_i >>> 1);
    qr = width'(d_r >>> 1);
    qi = width'(d_i >>> 1);
  end

endmodule

// File: rtl/high_speed_ifft.sv
// 8-point radix-2 DIT inverse FFT, iterated over three stages with four
// shared butterflies; the per-stage >>>1 gives the 1/8 normalisation.
//   clk, rstn          : clock, asynchronous active-low reset
//   in_vld / in_rdy    : spectrum handshake (accepted only in IDLE)
//   y0r..y7r, y0i..y7i : input spectrum bins, signed width bits
//   x0r..x7r, x0i..x7i : time samples, held until the next block completes
//   vld                : one-cycle pulse when x* update
//   counter_o          : current state (0 = IDLE, 1..3 = stage)
// Accept period is 4 cycles; results appear 3 edges after the accept edge.
module high_speed_ifft
  import ifft_pkg::*;
#(
  parameter int width = 9,
  parameter int tw_c  = TW_C_DEF,
  parameter int tw_sh = TW_SH_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic signed [width-1:0] y0r, y1r, y2r, y3r, y4r, y5r, y6r, y7r,
  input  logic signed [width-1:0] y0i, y1i, y2i, y3i, y4i, y5i, y6i, y7i,
  output logic signed [width-1:0] x0r, x1r, x2r, x3r, x4r, x5r, x6r, x7r,
  output logic signed [width-1:0] x0i, x1i, x2i, x3i, x4i, x5i, x6i, x7i,
  output logic                    vld,
  output logic [1:0]              counter_o
);

  state_t state, state_nx;

  logic signed [width-1:0] y_r [8], y_i [8];
  logic signed [width-1:0] r_r [8], r_i [8];
  logic signed [width-1:0] nr_r [8], nr_i [8];
  logic signed [width-1:0] x_r [8], x_i [8];

  // Butterfly operand routing for the current stage.
  logic [2:0]              ia [4], ib [4];
  tw_sel_t                 tw [4];
  logic signed [width-1:0] ba_r [4], ba_i [4], bb_r [4], bb_i [4];
  logic signed [width-1:0] bp_r [4], bp_i [4], bq_r [4], bq_i [4];

  always_comb begin
    y_r[0] = y0r; y_r[1] = y1r; y_r[2] = y2r; y_r[3] = y3r;
    y_r[4] = y4r; y_r[5] = y5r; y_r[6] = y6r; y_r[7] = y7r;
    y_i[0] = y0i; y_i[1] = y1i; y_i[2] = y2i; y_i[3] = y3i;
    y_i[4] = y4i; y_i[5] = y5i; y_i[6] = y6i; y_i[7] = y7i;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_vld) state_nx = S1;
      S1:      state_nx = S2;
      S2:      state_nx = S3;
      S3:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs: handshake and per-stage pair/twiddle selection.
  always_comb begin
    in_rdy = (state == IDLE);
    for (int unsigned k = 0; k < 4; k++) begin
      ia[k] = 3'(2 * k);
      ib[k] = 3'(2 * k + 1);
      tw[k] = TW_1;
    end
    case (state)
      S2: begin
        ia = '{3'd0, 3'd1, 3'd4, 3'd5};
        ib = '{3'd2, 3'd3, 3'd6, 3'd7};
        tw = '{TW_1, TW_J, TW_1, TW_J};
      end
      S3: begin
        ia = '{3'd0, 3'd1, 3'd2, 3'd3};
        ib = '{3'd4, 3'd5, 3'd6, 3'd7};
        tw = '{TW_1, TW_C1, TW_J, TW_C3};
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      ba_r[k] = r_r[ia[k]];
      ba_i[k] = r_i[ia[k]];
      bb_r[k] = r_r[ib[k]];
      bb_i[k] = r_i[ib[k]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bfly
    ifft_bfly #(
      .width (width),
      .tw_c  (tw_c),
      .tw_sh (tw_sh)
    ) u_bfly (
      .ar     (ba_r[g]),
      .ai     (ba_i[g]),
      .br     (bb_r[g]),
      .bi     (bb_i[g]),
      .tw_sel (tw[g]),
      .pr     (bp_r[g]),
      .pi     (bp_i[g]),
      .qr     (bq_r[g]),
      .qi     (bq_i[g])
    );
  end

  // In-place write-back: each stage touches all eight registers exactly once.
  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      nr_r[k] = r_r[k];
      nr_i[k] = r_i[k];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      nr_r[ia[k]] = bp_r[k];
      nr_i[ia[k]] = bp_i[k];
      nr_r[ib[k]] = bq_r[k];
      nr_i[ib[k]] = bq_i[k];
    end
  end

  // Working registers, output registers and the completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < 8; k++) begin
        r_r[k] <= '0;
        r_i[k] <= '0;
        x_r[k] <= '0;
        x_i[k] <= '0;
      end
      vld <= 1'b0;
    end else begin
      vld <= (state == S3);
      case (state)
        IDLE: begin
          if (in_vld) begin
            for (int unsigned k = 0; k < 8; k++) begin
              r_r[k] <= y_r[bitrev3(3'(k))];
              r_i[k] <= y_i[bitrev3(3'(k))];
            end
          end
        end
        S1, S2: begin
          for (int unsigned k = 0; k < 8; k++) begin
            r_r[k] <= nr_r[k];
            r_i[k] <= nr_i[k];
          end
        end
        S3: begin
          for (int unsigned k = 0; k < 8; k++) begin
            r_r[k] <= nr_r[k];
            r_i[k] <= nr_i[k];
            x_r[k] <= nr_r[k];
            x_i[k] <= nr_i[k];
          end
        end
        default: ;
      endcase
    end
  end

  assign counter_o = state;

  assign x0r = x_r[0]; assign x1r = x_r[1]; assign x2r = x_r[2]; assign x3r = x_r[3];
  assign x4r = x_r[4]; assign x5r = x_r[5]; assign x6r = x_r[6]; assign x7r = x_r[7];
  assign x0i = x_i[0]; assign x1i = x_i[1]; assign x2i = x_i[2]; assign x3i = x_i[3];
  assign x4i = x_i[4]; assign x5i = x_i[5]; assign x6i = x_i[6]; assign x7i = x_i[7];

endmodule

// File: tb/tb_high_speed_ifft.sv
// Directed bench for high_speed_ifft: reset state, impulse, constant,
// bin-2 and bin-1 spectra, back-to-back round trip, and mid-block reset.
module tb_high_speed_ifft;

  logic clk = 1'b0;
  logic rstn, in_vld, in_rdy, vld;
  logic [1:0] counter_o;
  logic signed [8:0] yr [8], yi [8], xr [8], xi [8];

  int vr [8], vi [8], er [8], ei [8];
  int tests = 0;
  int fails = 0;
  int lat, p1, p2, npulse, d;

  always #5 clk = ~clk;

  high_speed_ifft #(
    .width (9),
    .tw_c  (181),
    .tw_sh (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .y0r (yr[0]), .y1r (yr[1]), .y2r (yr[2]), .y3r (yr[3]),
    .y4r (yr[4]), .y5r (yr[5]), .y6r (yr[6]), .y7r (yr[7]),
    .y0i (yi[0]), .y1i (yi[1]), .y2i (yi[2]), .y3i (yi[3]),
    .y4i (yi[4]), .y5i (yi[5]), .y6i (yi[6]), .y7i (yi[7]),
    .x0r (xr[0]), .x1r (xr[1]), .x2r (xr[2]), .x3r (xr[3]),
    .x4r (xr[4]), .x5r (xr[5]), .x6r (xr[6]), .x7r (xr[7]),
    .x0i (xi[0]), .x1i (xi[1]), .x2i (xi[2]), .x3i (xi[3]),
    .x4i (xi[4]), .x5i (xi[5]), .x6i (xi[6]), .x7i (xi[7]),
    .vld       (vld),
    .counter_o (counter_o)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_y();
    for (int k = 0; k < 8; k++) begin
      yr[k] = vr[k][8:0];
      yi[k] = vi[k][8:0];
    end
  endtask

  task automatic scramble_y();
    for (int k = 0; k < 8; k++) begin
      yr[k] = 9'(37 * k + 5);
      yi[k] = 9'(-(29 * k + 3));
    end
  endtask

  task automatic check_x(input string tag);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s x%0dr", tag, n), xr[n], er[n]);
      chk($sformatf("%s x%0di", tag, n), xi[n], ei[n]);
    end
  endtask

  // One isolated block: accept, wait (bounded) for vld, check, check hold.
  task automatic run_block(input string tag);
    apply_y();
    in_vld = 1'b1;
    chk({tag, " rdy_idle"}, in_rdy, 1);
    tick();
    in_vld = 1'b0;
    scramble_y();
    chk({tag, " state_s1"}, counter_o, 1);
    chk({tag, " rdy_busy"}, in_rdy, 0);
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      tick();
      if (vld) lat = c;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " state_idle"}, counter_o, 0);
    check_x(tag);
    tick();
    chk({tag, " vld_one_cycle"}, vld, 0);
    chk({tag, " hold x0r"}, xr[0], er[0]);
    chk({tag, " hold x7i"}, xi[7], ei[7]);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rstn   = 1'b0;
    in_vld = 1'b0;
    vr = '{default: 0};
    vi = '{default: 0};
    apply_y();
    repeat (2) @(posedge clk);
    #1;
    chk("reset counter", counter_o, 0);
    chk("reset in_rdy", in_rdy, 1);
    chk("reset vld", vld, 0);
    er = '{default: 0};
    ei = '{default: 0};
    check_x("reset");
    rstn = 1'b1;
    tick();

    // Impulse in bin 0: flat time signal of 8/8.
    vr = '{8, 0, 0, 0, 0, 0, 0, 0};
    vi = '{default: 0};
    er = '{default: 1};
    ei = '{default: 0};
    run_block("impulse");

    // Constant spectrum: all energy lands in x0.
    vr = '{default: 8};
    vi = '{default: 0};
    er = '{8, 0, 0, 0, 0, 0, 0, 0};
    ei = '{default: 0};
    run_block("const");

    // Bin 2: exercises the stage-2 +j twiddle.
    vr = '{0, 0, 16, 0, 0, 0, 0, 0};
    vi = '{default: 0};
    er = '{2, 0, -2, 0, 2, 0, -2, 0};
    ei = '{0, 2, 0, -2, 0, 2, 0, -2};
    run_block("bin2");

    // Bin 1: stage-3 twiddles; 16*181>>>8 = 11, -(16*181)>>>8 = -12.
    vr = '{0, 64, 0, 0, 0, 0, 0, 0};
    vi = '{default: 0};
    er = '{8, 5, 0, -6, -8, -6, 0, 6};
    ei = '{0, 5, 8, 5, 0, -6, -8, -6};
    run_block("bin1");

    // Round trip: rounded forward DFT of x[n] = 2^n, two blocks back to back.
    vr = '{255, 49, -51, -79, -85, -79, -51, 49};
    vi = '{0, 166, 102, 46, 0, -46, -102, -166};
    er = '{1, 2, 4, 7, 16, 32, 64, 128};
    ei = '{default: 0};
    apply_y();
    in_vld = 1'b1;
    p1 = -1;
    p2 = -1;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) begin
        chk("b2b second accept", counter_o, 1);
        in_vld = 1'b0;
      end
      if (counter_o != 2'd0) chk($sformatf("b2b rdy_busy c%0d", i), in_rdy, 0);
      if (vld) begin
        npulse++;
        if (p1 < 0) p1 = i;
        else        p2 = i;
        check_x($sformatf("b2b blk%0d", npulse));
        for (int n = 0; n < 8; n++) begin
          d = int'(xr[n]) - (1 << n);
          chk($sformatf("rt x%0dr within 2", n), (d >= -2 && d <= 2), 1);
          d = int'(xi[n]);
          chk($sformatf("rt x%0di within 2", n), (d >= -2 && d <= 2), 1);
        end
      end
    end
    chk("b2b pulse count", npulse, 2);
    chk("b2b first pulse", p1, 3);
    chk("b2b pulse spacing", p2 - p1, 4);

    // Reset while in S2: outputs from the round trip are nonzero beforehand.
    vr = '{8, 0, 0, 0, 0, 0, 0, 0};
    vi = '{default: 0};
    apply_y();
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    chk("abort pre state_s2", counter_o, 2);
    #2 rstn = 1'b0;
    #1;
    chk("abort counter", counter_o, 0);
    chk("abort in_rdy", in_rdy, 1);
    chk("abort vld", vld, 0);
    er = '{default: 0};
    ei = '{default: 0};
    check_x("abort");
    @(negedge clk);
    rstn = 1'b1;
    npulse = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (vld) npulse++;
    end
    chk("abort no vld", npulse, 0);
    chk("abort stays idle", counter_o, 0);

    // Recovery after the aborted block.
    vr = '{8, 0, 0, 0, 0, 0, 0, 0};
    vi = '{default: 0};
    er = '{default: 1};
    ei = '{default: 0};
    run_block("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
